riscv_axil_sram: RTL and testbench
==================================

# riscv_axil_sram

Parametrised AXI4-Lite slave SRAM for the RISC-V subsystem: the next-generation data/instruction memory behind the core's AXI4-Lite master port. Independent read and write engines serve concurrent traffic. AW and W are accepted in any order, WSTRB byte lanes are honoured, and out-of-range accesses return DECERR. A synthesizable console-byte port replaces simulation-only printing.

## Interface
- DATA_W, 32: data bus width; 32 or 64 only.
- ADDR_W, 32: AXI address width.
- DEPTH, 1024: memory words of DATA_W bits; power of two.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to DEPTH*DATA_W/8.
- UART_EN, 1: enables the console register.
- UART_ADDR, 32'h8000_0000: console register byte address, outside the RAM window.
- clk  in  1  the single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  ADDR_W/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  ADDR_W/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_W/2/1/1  read data channel.
- uart_valid  out  1  one-cycle pulse per console write.
- uart_data  out  8  console byte; valid only while uart_valid is high.

## Operation
- Decode: a RAM hit is BASE_ADDR <= addr < BASE_ADDR+DEPTH*BYTES, where BYTES=DATA_W/8.
  - Word index = (addr-BASE_ADDR)>>log2(BYTES). Low address bits are ignored.
  - Console hit: UART_EN=1 and addr[ADDR_W-1:log2(BYTES)] equals the same field of UART_ADDR.
  - Any other address is a miss and returns DECERR (2'b11).
- Write FSM states: W_IDLE, W_HAVE_A (AW latched, W pending), W_HAVE_D (W latched, AW pending), W_RESP.
  - AWREADY=1 in W_IDLE and W_HAVE_D. WREADY=1 in W_IDLE and W_HAVE_A.
  - Handshakes complete independently. A same-cycle AW+W handshake in W_IDLE goes directly to commit.
  - Commit happens on the edge where the second handshake completes.
  - RAM hit: write the bytes selected by WSTRB; other bytes are unchanged. WSTRB=0 writes nothing. BRESP=OKAY.
  - Console hit: if WSTRB[0]=1, pulse uart_valid with uart_data=WDATA[7:0]; if WSTRB[0]=0, no pulse. BRESP=OKAY in both cases.
  - Miss: memory unchanged, BRESP=DECERR.
  - After commit, state goes to W_RESP. BVALID and BRESP hold until BREADY, then state returns to W_IDLE.
- Read FSM states: R_IDLE (ARREADY=1) and R_RESP (ARREADY=0).
  - On an AR handshake, capture the response and go to R_RESP:
    - RAM hit: RDATA=RAM word, RRESP=OKAY.
    - Console hit: RDATA=0, RRESP=OKAY.
    - Miss: RDATA=0, RRESP=DECERR.
  - RVALID, RDATA and RRESP hold stable until RREADY, then state returns to R_IDLE.
- Read and write engines never block each other.
- A read and a write to the same word committing on the same edge: the read returns the old data.

## Timing
- Reset values, driven asynchronously while rst=1:
  - All READY, VALID and response outputs = 0.
  - RDATA = 0, uart_valid = 0, uart_data = 0.
  - Both FSMs in IDLE; latched AW/W state is cleared.
- On the first rising edge after rst falls, AWREADY, WREADY and ARREADY rise to 1.
- Write latency: BVALID=1 in the cycle after the last of the AW/W handshakes. uart_valid pulses in that same cycle.
- Read latency: RVALID=1 in the cycle after the AR handshake. This requires a synchronous RAM read.
- Throughput: at most one read and one write every 2 cycles when BREADY=RREADY=1 is held.
- Reset asserted mid-transaction:
  - The outstanding transaction is dropped and no response is issued.
  - A write whose commit edge has not occurred leaves memory unchanged.
  - Memory contents are not cleared by reset.

## Structure
- Package riscv_axil_pkg holds:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - The write-FSM and read-FSM state enums.
  - A function computing the decode result (hit, console, miss).
- One sub-module, riscv_sram_1r1w: DEPTH x DATA_W, one write port with per-byte enables, one synchronous read port, read-before-write on address collision. The top level contains the two FSMs and the decode.

## Test plan
- Reset, then on the same cycle AW=0x10, W=0xDEADBEEF, WSTRB=0xF -> B OKAY one cycle later. Then AR=0x10 -> RDATA=0xDEADBEEF, RVALID one cycle after the AR handshake.
- W=0x11223344 with WSTRB=0x5 issued 3 cycles before AW=0x10 (memory word at 0x10 = 0xDEADBEEF) -> B OKAY. Readback = 0xDE22BE44.
- AW=0x8000_0000, W=0x41, WSTRB=0x1 -> one-cycle uart_valid with uart_data=0x41, BRESP=OKAY. Repeat with WSTRB=0x2 -> no pulse, BRESP=OKAY.
- AR=0x1000 and a write to 0x2000, with DEPTH=1024 and DATA_W=32 -> RRESP=DECERR with RDATA=0, BRESP=DECERR, memory unchanged.
- Hold BREADY=0 and RREADY=0 for 5 cycles -> BVALID/BRESP and RVALID/RDATA/RRESP stay stable and the READY outputs stay low. A read concurrent with the stalled write still completes.
- Assert rst while in W_HAVE_A -> all outputs drop to 0 at once. After release, no B response appears and the target word is unchanged.

Source files
------------

// File: rtl/riscv_axil_pkg.sv
// riscv_axil_pkg: response codes, FSM state types and address decode shared
// by the AXI4-Lite SRAM slave.
package riscv_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_RESP} r_state_e;
   typedef enum logic [1:0] {DEC_MISS, DEC_RAM, DEC_CONSOLE} dec_e;

   // Operands are widened to 64 bits so BASE+SPAN cannot overflow the bus width.
   function automatic dec_e decode(input logic [63:0] addr,
                                   input logic [63:0] base,
                                   input logic [63:0] span,
                                   input logic [63:0] uart_addr,
                                   input int unsigned lsb,
                                   input logic        uart_en);
      dec_e d;
      d = DEC_MISS;
      if (addr >= base && (addr - base) < span)
         d = DEC_RAM;
      else if (uart_en && ((addr >> lsb) == (uart_addr >> lsb)))
         d = DEC_CONSOLE;
      return d;
   endfunction

endpackage

// File: rtl/riscv_sram_1r1w.sv
// riscv_sram_1r1w: DEPTH x DATA_W memory with a byte-enabled write port and a
// registered read port; a same-address read and write return the old word.
module riscv_sram_1r1w #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned AW     = 10
) (
   input  logic                clk,
   input  logic [DATA_W/8-1:0] we,
   input  logic [AW-1:0]       waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic                re,
   input  logic [AW-1:0]       raddr,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (re)
         rdata <= mem[raddr];
      for (int unsigned b = 0; b < DATA_W / 8; b++) begin
         if (we[b])
            mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
   end

endmodule

// File: rtl/riscv_axil_sram.sv
// riscv_axil_sram: AXI4-Lite slave SRAM with independent read/write engines,
// WSTRB byte lanes, DECERR on unmapped addresses and a console byte port.
module riscv_axil_sram
   import riscv_axil_pkg::*;
#(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter bit                UART_EN   = 1'b1,
   parameter logic [ADDR_W-1:0] UART_ADDR = ADDR_W'(32'h8000_0000)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
   input  logic                S_AXI_AWVALID,
   output logic                S_AXI_AWREADY,
   input  logic [DATA_W-1:0]   S_AXI_WDATA,
   input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
   input  logic                S_AXI_WVALID,
   output logic                S_AXI_WREADY,
   output logic [1:0]          S_AXI_BRESP,
   output logic                S_AXI_BVALID,
   input  logic                S_AXI_BREADY,
   input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
   input  logic                S_AXI_ARVALID,
   output logic                S_AXI_ARREADY,
   output logic [DATA_W-1:0]   S_AXI_RDATA,
   output logic [1:0]          S_AXI_RRESP,
   output logic                S_AXI_RVALID,
   input  logic                S_AXI_RREADY,
   output logic                uart_valid,
   output logic [7:0]          uart_data
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned LSB   = $clog2(BYTES);
   localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'(BYTES);

   w_state_e            w_state, w_next;
   r_state_e            r_state, r_next;
   logic                live;
   logic [ADDR_W-1:0]   aw_addr_q;
   logic [DATA_W-1:0]   w_data_q;
   logic [BYTES-1:0]    w_strb_q;
   logic                aw_hs, w_hs, ar_hs, commit, uart_fire, rd_ram_q;
   logic [ADDR_W-1:0]   c_addr;
   logic [DATA_W-1:0]   c_data;
   logic [BYTES-1:0]    c_strb, ram_we;
   dec_e                w_dec, r_dec;
   logic [AW-1:0]       w_idx, r_idx;
   logic [DATA_W-1:0]   ram_q;

   // READY stays low until the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) live <= 1'b0;
      else     live <= 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) w_state <= W_IDLE;
      else     w_state <= w_next;
   end

   // The commit operand comes from the latch for the channel that arrived first.
   always_comb begin
      w_next        = w_state;
      S_AXI_AWREADY = 1'b0;
      S_AXI_WREADY  = 1'b0;
      commit        = 1'b0;
      c_addr        = S_AXI_AWADDR;
      c_data        = S_AXI_WDATA;
      c_strb        = S_AXI_WSTRB;
      case (w_state)
         W_IDLE: begin
            S_AXI_AWREADY = live;
            S_AXI_WREADY  = live;
         end
         W_HAVE_A: begin
            S_AXI_WREADY = 1'b1;
            c_addr       = aw_addr_q;
         end
         W_HAVE_D: begin
            S_AXI_AWREADY = 1'b1;
            c_data        = w_data_q;
            c_strb        = w_strb_q;
         end
         default: ;
      endcase
      aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
      w_hs  = S_AXI_WVALID && S_AXI_WREADY;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit = 1'b1;
               w_next = W_RESP;
            end else if (aw_hs) begin
               w_next = W_HAVE_A;
            end else if (w_hs) begin
               w_next = W_HAVE_D;
            end
         end
         W_HAVE_A: if (w_hs) begin
            commit = 1'b1;
            w_next = W_RESP;
         end
         W_HAVE_D: if (aw_hs) begin
            commit = 1'b1;
            w_next = W_RESP;
         end
         W_RESP: if (S_AXI_BREADY) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
      w_dec     = decode(64'(c_addr), 64'(BASE_ADDR), SPAN, 64'(UART_ADDR), LSB, UART_EN);
      w_idx     = AW'((64'(c_addr) - 64'(BASE_ADDR)) >> LSB);
      uart_fire = commit && (w_dec == DEC_CONSOLE) && c_strb[0];
      ram_we    = (commit && w_dec == DEC_RAM) ? c_strb : '0;
   end

   assign S_AXI_BVALID = (w_state == W_RESP);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         aw_addr_q   <= '0;
         w_data_q    <= '0;
         w_strb_q    <= '0;
         S_AXI_BRESP <= RESP_OKAY;
         uart_valid  <= 1'b0;
         uart_data   <= '0;
      end else begin
         if (aw_hs)
            aw_addr_q <= S_AXI_AWADDR;
         if (w_hs) begin
            w_data_q <= S_AXI_WDATA;
            w_strb_q <= S_AXI_WSTRB;
         end
         if (commit)
            S_AXI_BRESP <= (w_dec == DEC_MISS) ? RESP_DECERR : RESP_OKAY;
         uart_valid <= uart_fire;
         if (uart_fire)
            uart_data <= c_data[7:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= R_IDLE;
      else     r_state <= r_next;
   end

   always_comb begin
      r_next        = r_state;
      S_AXI_ARREADY = 1'b0;
      case (r_state)
         R_IDLE: begin
            S_AXI_ARREADY = live;
            if (live && S_AXI_ARVALID) r_next = R_RESP;
         end
         R_RESP: if (S_AXI_RREADY) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
   assign r_dec = decode(64'(S_AXI_ARADDR), 64'(BASE_ADDR), SPAN, 64'(UART_ADDR), LSB, UART_EN);
   assign r_idx = AW'((64'(S_AXI_ARADDR) - 64'(BASE_ADDR)) >> LSB);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         S_AXI_RRESP <= RESP_OKAY;
         rd_ram_q    <= 1'b0;
      end else if (ar_hs) begin
         S_AXI_RRESP <= (r_dec == DEC_MISS) ? RESP_DECERR : RESP_OKAY;
         rd_ram_q    <= (r_dec == DEC_RAM);
      end
   end

   // The RAM read register is only loaded on AR, so it holds through a stall.
   assign S_AXI_RVALID = (r_state == R_RESP);
   assign S_AXI_RDATA  = (S_AXI_RVALID && rd_ram_q) ? ram_q : '0;

   riscv_sram_1r1w #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (w_idx),
      .wdata (c_data),
      .re    (ar_hs),
      .raddr (r_idx),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_riscv_axil_sram.sv
// tb_riscv_axil_sram: directed and randomized AXI4-Lite traffic checked
// against a word/byte-mask memory model of the default 4 KiB RAM window.
module tb_riscv_axil_sram;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] S_AXI_AWADDR, S_AXI_WDATA, S_AXI_ARADDR, S_AXI_RDATA;
   logic [3:0]  S_AXI_WSTRB;
   logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
   logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
   logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
   logic        S_AXI_RVALID, S_AXI_RREADY, uart_valid;
   logic [7:0]  uart_data;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] mem_m [1024];
   logic [3:0]  kb    [1024];
   logic [31:0] rd;
   logic [1:0]  rr;

   riscv_axil_sram dut (
      .clk           (clk),
      .rst           (rst),
      .S_AXI_AWADDR  (S_AXI_AWADDR),
      .S_AXI_AWVALID (S_AXI_AWVALID),
      .S_AXI_AWREADY (S_AXI_AWREADY),
      .S_AXI_WDATA   (S_AXI_WDATA),
      .S_AXI_WSTRB   (S_AXI_WSTRB),
      .S_AXI_WVALID  (S_AXI_WVALID),
      .S_AXI_WREADY  (S_AXI_WREADY),
      .S_AXI_BRESP   (S_AXI_BRESP),
      .S_AXI_BVALID  (S_AXI_BVALID),
      .S_AXI_BREADY  (S_AXI_BREADY),
      .S_AXI_ARADDR  (S_AXI_ARADDR),
      .S_AXI_ARVALID (S_AXI_ARVALID),
      .S_AXI_ARREADY (S_AXI_ARREADY),
      .S_AXI_RDATA   (S_AXI_RDATA),
      .S_AXI_RRESP   (S_AXI_RRESP),
      .S_AXI_RVALID  (S_AXI_RVALID),
      .S_AXI_RREADY  (S_AXI_RREADY),
      .uart_valid    (uart_valid),
      .uart_data     (uart_data)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic bit m_ram(input logic [31:0] a);
      return a < 32'h1000;
   endfunction

   function automatic bit m_con(input logic [31:0] a);
      return (a >> 2) == (32'h8000_0000 >> 2);
   endfunction

   function automatic logic [31:0] bmask(input logic [3:0] s);
      return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
   endfunction

   function automatic logic [63:0] all_outs();
      return 64'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID,
                  S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA, uart_valid, uart_data});
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      if (m_ram(a)) begin
         idx        = int'(a >> 2);
         mem_m[idx] = (mem_m[idx] & ~bmask(s)) | (d & bmask(s));
         kb[idx]    = kb[idx] | s;
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
      int cyc;
      bit aw_done, w_done, aw_now, w_now, exp_uart;
      cyc = 0; aw_done = 0; w_done = 0;
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      while (!(aw_done && w_done) && cyc < 40) begin
         S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
         S_AXI_WVALID  = !w_done && cyc >= w_dly;
         aw_now = S_AXI_AWVALID && S_AXI_AWREADY;
         w_now  = S_AXI_WVALID && S_AXI_WREADY;
         chk("bvalid_early", S_AXI_BVALID, 0);
         if (aw_done) chk("awready_after_aw", S_AXI_AWREADY, 0);
         if (w_done)  chk("wready_after_w", S_AXI_WREADY, 0);
         step();
         aw_done = aw_done || aw_now;
         w_done  = w_done || w_now;
         cyc++;
      end
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      chk("write_handshakes", {aw_done, w_done}, 2'b11);
      exp_uart = m_con(a) && s[0];
      chk("bvalid", S_AXI_BVALID, 1);
      chk("bresp", S_AXI_BRESP, (m_ram(a) || m_con(a)) ? 2'b00 : 2'b11);
      chk("uart_valid", uart_valid, exp_uart);
      if (exp_uart) chk("uart_data", uart_data, d[7:0]);
      m_write(a, d, s);
      S_AXI_BREADY = 1; step(); S_AXI_BREADY = 0;
      chk("bvalid_clear", S_AXI_BVALID, 0);
      chk("uart_pulse_end", uart_valid, 0);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      int cyc, idx;
      cyc = 0;
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
      while (!S_AXI_ARREADY && cyc < 40) begin
         step();
         cyc++;
      end
      chk("arready", S_AXI_ARREADY, 1);
      step(); S_AXI_ARVALID = 0;
      chk("rvalid", S_AXI_RVALID, 1);
      d = S_AXI_RDATA; r = S_AXI_RRESP;
      if (m_ram(a)) begin
         idx = int'(a >> 2);
         chk("rresp_ram", r, 2'b00);
         chk("rdata_ram", d & bmask(kb[idx]), mem_m[idx] & bmask(kb[idx]));
      end else begin
         chk("rresp_other", r, m_con(a) ? 2'b00 : 2'b11);
         chk("rdata_zero", d, 0);
      end
      S_AXI_RREADY = 1; step(); S_AXI_RREADY = 0;
      chk("rvalid_clear", S_AXI_RVALID, 0);
   endtask

   initial begin
      logic [31:0] a;
      int          k;
      for (int i = 0; i < 1024; i++) begin
         mem_m[i] = '0;
         kb[i]    = '0;
      end
      rst = 1;
      S_AXI_AWADDR = '0; S_AXI_AWVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
      S_AXI_WVALID = 0; S_AXI_BREADY = 0; S_AXI_ARADDR = '0; S_AXI_ARVALID = 0;
      S_AXI_RREADY = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", all_outs(), 0);
      rst = 0;
      #1;
      chk("ready_before_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
      step();
      chk("ready_after_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

      do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      do_read(32'h10, rd, rr);
      chk("read_deadbeef", rd, 32'hDEADBEEF);
      do_write(32'h10, 32'h11223344, 4'h5, 3, 0);
      do_read(32'h10, rd, rr);
      chk("read_strb_merge", rd, 32'hDE22BE44);

      do_write(32'h8000_0000, 32'h41, 4'h1, 0, 0);
      do_write(32'h8000_0000, 32'h41, 4'h2, 0, 0);
      do_read(32'h8000_0000, rd, rr);

      do_write(32'h0, 32'hCAFEF00D, 4'hF, 0, 0);
      do_read(32'h1000, rd, rr);
      chk("miss_rresp", rr, 2'b11);
      do_write(32'h2000, 32'h12345678, 4'hF, 1, 0);
      do_read(32'h0, rd, rr);
      chk("miss_no_alias", rd, 32'hCAFEF00D);

      // Concurrent write and read of one word, both responses stalled.
      do_write(32'h20, 32'hA5A50001, 4'hF, 0, 0);
      S_AXI_AWADDR = 32'h20; S_AXI_WDATA = 32'h5A5A0002; S_AXI_WSTRB = 4'hF;
      S_AXI_ARADDR = 32'h20;
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
      step();
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_b", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
         chk("stall_r", {S_AXI_RVALID, S_AXI_RRESP, S_AXI_RDATA}, {1'b1, 2'b00, 32'hA5A50001});
         chk("stall_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b000);
         step();
      end
      m_write(32'h20, 32'h5A5A0002, 4'hF);
      S_AXI_RREADY = 1; step(); S_AXI_RREADY = 0;
      chk("stall_r_release", {S_AXI_RVALID, S_AXI_BVALID}, 2'b01);
      do_read(32'h20, rd, rr);
      chk("read_during_b_stall", rd, 32'h5A5A0002);
      chk("b_still_stalled", S_AXI_BVALID, 1);
      S_AXI_BREADY = 1; step(); S_AXI_BREADY = 0;
      chk("b_release", S_AXI_BVALID, 0);

      // Reset while an AW is latched and W is still pending.
      do_write(32'h30, 32'h0BADF00D, 4'hF, 0, 0);
      S_AXI_AWADDR = 32'h30; S_AXI_AWVALID = 1;
      step();
      S_AXI_AWVALID = 0;
      chk("have_a_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b01);
      rst = 1;
      #1;
      chk("reset_async", all_outs(), 0);
      step(); step();
      rst = 0;
      step();
      S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1;
      step();
      S_AXI_WVALID = 0;
      for (int i = 0; i < 3; i++) begin
         chk("no_b_after_reset", S_AXI_BVALID, 0);
         step();
      end
      S_AXI_AWADDR = 32'h40; S_AXI_AWVALID = 1;
      step();
      S_AXI_AWVALID = 0;
      chk("w_first_b", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
      m_write(32'h40, 32'hFFFFFFFF, 4'hF);
      S_AXI_BREADY = 1; step(); S_AXI_BREADY = 0;
      do_read(32'h30, rd, rr);
      chk("reset_word_unchanged", rd, 32'h0BADF00D);
      do_read(32'h40, rd, rr);

      for (int n = 0; n < 300; n++) begin
         k = int'($urandom_range(0, 9));
         if (k < 7)
            a = ($urandom_range(0, 31) << 2) | $urandom_range(0, 3);
         else if (k == 7)
            a = 32'h8000_0000 | $urandom_range(0, 3);
         else
            a = $urandom_range(32'h1000, 32'h7FFF_FFFF);
         if ($urandom_range(0, 1) == 0)
            do_write(a, $urandom, 4'($urandom_range(0, 15)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         else
            do_read(a, rd, rr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
